// File: rtl/alu_unit_if.sv
// Operand/result bundle between the execute-stage ALU and its surroundings.
// master drives operands and observes results; slave is the ALU itself.
interface alu_unit_if;
    logic        in_valid;
    logic [3:0]  alu_op;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b_reg;
    logic [15:0] imm16;
    logic        ext_op;
    logic        alu_src;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        carry;
    logic [31:0] ext_out;

    modport master (
        output in_valid, alu_op, func, a, b_reg, imm16, ext_op, alu_src,
        input  out_valid, result, zero, overflow, carry, ext_out
    );

    modport slave (
        input  in_valid, alu_op, func, a, b_reg, imm16, ext_op, alu_src,
        output out_valid, result, zero, overflow, carry, ext_out
    );
endinterface

// File: rtl/alu_unit.sv
// Execute-stage ALU: control decode, immediate extension, 32-bit ALU with flags.
// Results and flags are registered with one-cycle latency.
module alu_unit (
    input  logic       clk,
    input  logic       rst,
    alu_unit_if.slave  bus
);
    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_ADDU = 4'h1, OP_SUB  = 4'h2, OP_SUBU = 4'h3,
        OP_AND  = 4'h4, OP_OR   = 4'h5, OP_XOR  = 4'h6, OP_NOR  = 4'h7,
        OP_SLT  = 4'h8, OP_SLTU = 4'h9, OP_SLL  = 4'hA, OP_SRL  = 4'hB,
        OP_SRA  = 4'hC, OP_LUI  = 4'hD, OP_ZERO = 4'hE, OP_RTYPE = 4'hF
    } alu_ctr_e;

    alu_ctr_e    alu_ctr;
    logic [31:0] ext_val;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [32:0] sum;
    logic [32:0] diff;

    logic [31:0] result_d, result_q;
    logic        overflow_d, overflow_q;
    logic        carry_d, carry_q;
    logic        zero_q;
    logic        out_valid_q;

    assign ext_val = bus.ext_op ? {{16{bus.imm16[15]}}, bus.imm16} : {16'b0, bus.imm16};
    assign op_b    = bus.alu_src ? ext_val : bus.b_reg;
    assign shamt   = bus.a[4:0];
    assign sum     = {1'b0, bus.a} + {1'b0, op_b};
    // Subtract as A + ~B + 1 so bit 32 is the MIPS-style no-borrow flag.
    assign diff    = {1'b0, bus.a} + {1'b0, ~op_b} + 33'd1;

    always_comb begin
        alu_ctr = alu_ctr_e'(bus.alu_op);
        if (bus.alu_op == OP_RTYPE) begin
            casez (bus.func)
                6'b000?00: alu_ctr = OP_SLL;
                6'b000?10: alu_ctr = OP_SRL;
                6'b000?11: alu_ctr = OP_SRA;
                6'b100000: alu_ctr = OP_ADD;
                6'b100001: alu_ctr = OP_ADDU;
                6'b100010: alu_ctr = OP_SUB;
                6'b100011: alu_ctr = OP_SUBU;
                6'b100100: alu_ctr = OP_AND;
                6'b100101: alu_ctr = OP_OR;
                6'b100110: alu_ctr = OP_XOR;
                6'b100111: alu_ctr = OP_NOR;
                6'b101010: alu_ctr = OP_SLT;
                6'b101011: alu_ctr = OP_SLTU;
                default:   alu_ctr = OP_ADDU;
            endcase
        end
    end

    always_comb begin
        result_d   = 32'b0;
        overflow_d = 1'b0;
        carry_d    = 1'b0;
        case (alu_ctr)
            OP_ADD: begin
                result_d   = sum[31:0];
                carry_d    = sum[32];
                overflow_d = (bus.a[31] == op_b[31]) && (sum[31] != bus.a[31]);
            end
            OP_ADDU: begin
                result_d = sum[31:0];
                carry_d  = sum[32];
            end
            OP_SUB: begin
                result_d   = diff[31:0];
                carry_d    = diff[32];
                overflow_d = (bus.a[31] != op_b[31]) && (diff[31] != bus.a[31]);
            end
            OP_SUBU: begin
                result_d = diff[31:0];
                carry_d  = diff[32];
            end
            OP_AND:  result_d = bus.a & op_b;
            OP_OR:   result_d = bus.a | op_b;
            OP_XOR:  result_d = bus.a ^ op_b;
            OP_NOR:  result_d = ~(bus.a | op_b);
            OP_SLT:  result_d = {31'b0, $signed(bus.a) < $signed(op_b)};
            OP_SLTU: result_d = {31'b0, bus.a < op_b};
            OP_SLL:  result_d = op_b << shamt;
            OP_SRL:  result_d = op_b >> shamt;
            OP_SRA:  result_d = $unsigned($signed(op_b) >>> shamt);
            OP_LUI:  result_d = {op_b[15:0], 16'b0};
            default: result_d = 32'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= 32'b0;
            zero_q      <= 1'b1;
            overflow_q  <= 1'b0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                result_q   <= result_d;
                zero_q     <= (result_d == 32'b0);
                overflow_q <= overflow_d;
                carry_q    <= carry_d;
            end
        end
    end

    assign bus.ext_out   = ext_val;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;
    assign bus.carry     = carry_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit: hand-computed results and flags,
// sampled 1 time unit after each rising edge.
module tb_alu_unit;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    alu_unit_if bus ();

    alu_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [31:0] res,
                             input logic z, input logic ov, input logic cy);
        chk({tag, ".result"},   bus.result,          res);
        chk({tag, ".zero"},     {31'b0, bus.zero},     {31'b0, z});
        chk({tag, ".overflow"}, {31'b0, bus.overflow}, {31'b0, ov});
        chk({tag, ".carry"},    {31'b0, bus.carry},    {31'b0, cy});
        chk({tag, ".valid"},    {31'b0, bus.out_valid}, 32'd1);
    endtask

    task automatic set_ops(input logic [3:0] op, input logic [5:0] fn,
                           input logic [31:0] av, input logic [31:0] bv,
                           input logic [15:0] im, input logic eo, input logic src);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.func     = fn;
        bus.a        = av;
        bus.b_reg    = bv;
        bus.imm16    = im;
        bus.ext_op   = eo;
        bus.alu_src  = src;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set_ops(4'h0, 6'h0, 32'd0, 32'd0, 16'h0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Load a nonzero result so the reset check below is meaningful
        set_ops(4'h0, 6'h0, 32'd3, 32'd4, 16'h0, 1'b0, 1'b0);
        tick();
        chk_flags("add3_4", 32'd7, 1'b0, 1'b0, 1'b0);

        rst = 1'b1;
        set_ops(4'h0, 6'h0, 32'h7FFFFFFF, 32'd1, 16'h0, 1'b0, 1'b0);
        tick();
        chk("rst.result", bus.result, 32'd0);
        chk("rst.zero", {31'b0, bus.zero}, 32'd1);
        chk("rst.overflow", {31'b0, bus.overflow}, 32'd0);
        chk("rst.carry", {31'b0, bus.carry}, 32'd0);
        chk("rst.valid", {31'b0, bus.out_valid}, 32'd0);
        rst = 1'b0;

        bus.in_valid = 1'b0;
        bus.imm16 = 16'h8001;
        bus.ext_op = 1'b1;
        #1;
        chk("ext.sign", bus.ext_out, 32'hFFFF8001);
        bus.ext_op = 1'b0;
        #1;
        chk("ext.zero", bus.ext_out, 32'h00008001);

        set_ops(4'h0, 6'h0, 32'd1, 32'h0, 16'h8001, 1'b1, 1'b1);
        tick();
        chk_flags("add_imm", 32'hFFFF8002, 1'b0, 1'b0, 1'b0);

        set_ops(4'h0, 6'h0, 32'h7FFFFFFF, 32'd1, 16'h0, 1'b0, 1'b0);
        tick();
        chk_flags("add_ovf", 32'h80000000, 1'b0, 1'b1, 1'b0);

        set_ops(4'h1, 6'h0, 32'hFFFFFFFF, 32'd1, 16'h0, 1'b0, 1'b0);
        tick();
        chk_flags("addu_wrap", 32'h0, 1'b1, 1'b0, 1'b1);

        set_ops(4'h0, 6'h0, 32'hFFFFFFFF, 32'd1, 16'h0, 1'b0, 1'b0);
        tick();
        chk_flags("add_wrap", 32'h0, 1'b1, 1'b0, 1'b1);

        set_ops(4'h2, 6'h0, 32'd5, 32'd5, 16'h0, 1'b0, 1'b0);
        tick();
        chk_flags("sub_eq", 32'h0, 1'b1, 1'b0, 1'b1);

        set_ops(4'h2, 6'h0, 32'h80000000, 32'd1, 16'h0, 1'b0, 1'b0);
        tick();
        chk_flags("sub_ovf", 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);

        set_ops(4'h3, 6'h0, 32'h80000000, 32'd1, 16'h0, 1'b0, 1'b0);
        tick();
        chk_flags("subu_noovf", 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);

        set_ops(4'h3, 6'h0, 32'd3, 32'd5, 16'h0, 1'b0, 1'b0);
        tick();
        chk_flags("subu_borrow", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);

        set_ops(4'hF, 6'b101010, 32'hFFFFFFFF, 32'd1, 16'h0, 1'b0, 1'b0);
        tick();
        chk_flags("r_slt", 32'd1, 1'b0, 1'b0, 1'b0);

        set_ops(4'hF, 6'b101011, 32'hFFFFFFFF, 32'd1, 16'h0, 1'b0, 1'b0);
        tick();
        chk_flags("r_sltu", 32'd0, 1'b1, 1'b0, 1'b0);

        set_ops(4'hF, 6'b111111, 32'hFFFFFFFF, 32'd1, 16'h0, 1'b0, 1'b0);
        tick();
        chk_flags("r_default_addu", 32'd0, 1'b1, 1'b0, 1'b1);

        set_ops(4'hF, 6'b100010, 32'd10, 32'd3, 16'h0, 1'b0, 1'b0);
        tick();
        chk_flags("r_sub", 32'd7, 1'b0, 1'b0, 1'b1);

        // Upper bits of A must not affect the shift amount
        set_ops(4'hF, 6'b000000, 32'hFFFFFFE4, 32'h80000010, 16'h0, 1'b0, 1'b0);
        tick();
        chk_flags("r_sll", 32'h00000100, 1'b0, 1'b0, 1'b0);

        set_ops(4'hF, 6'b000100, 32'd4, 32'h80000010, 16'h0, 1'b0, 1'b0);
        tick();
        chk("r_sllv.result", bus.result, 32'h00000100);

        set_ops(4'hF, 6'b000010, 32'd4, 32'h80000010, 16'h0, 1'b0, 1'b0);
        tick();
        chk_flags("r_srl", 32'h08000001, 1'b0, 1'b0, 1'b0);

        set_ops(4'hF, 6'b000011, 32'd4, 32'h80000010, 16'h0, 1'b0, 1'b0);
        tick();
        chk_flags("r_sra", 32'hF8000001, 1'b0, 1'b0, 1'b0);

        set_ops(4'hD, 6'h0, 32'h0, 32'hDEADBEEF, 16'h1234, 1'b0, 1'b1);
        tick();
        chk_flags("lui", 32'h12340000, 1'b0, 1'b0, 1'b0);

        set_ops(4'h4, 6'h0, 32'hF0F000FF, 32'h0FF00F0F, 16'h0, 1'b0, 1'b0);
        tick();
        chk("and.result", bus.result, 32'h00F0000F);
        set_ops(4'h5, 6'h0, 32'hF0F000FF, 32'h0FF00F0F, 16'h0, 1'b0, 1'b0);
        tick();
        chk("or.result", bus.result, 32'hFFF00FFF);
        set_ops(4'h6, 6'h0, 32'hF0F000FF, 32'h0FF00F0F, 16'h0, 1'b0, 1'b0);
        tick();
        chk("xor.result", bus.result, 32'hFF000FF0);
        set_ops(4'h7, 6'h0, 32'hF0F000FF, 32'h0FF00F0F, 16'h0, 1'b0, 1'b0);
        tick();
        chk("nor.result", bus.result, 32'h000FF000);

        set_ops(4'hE, 6'h0, 32'h12345678, 32'h1, 16'h0, 1'b0, 1'b0);
        tick();
        chk_flags("op_zero", 32'h0, 1'b1, 1'b0, 1'b0);

        // Back-to-back issue: each result appears one edge after its inputs
        set_ops(4'h1, 6'h0, 32'd100, 32'd23, 16'h0, 1'b0, 1'b0);
        tick();
        chk_flags("pipe1", 32'd123, 1'b0, 1'b0, 1'b0);
        set_ops(4'h5, 6'h0, 32'h0000F000, 32'h0000000F, 16'h0, 1'b0, 1'b0);
        tick();
        chk_flags("pipe2", 32'h0000F00F, 1'b0, 1'b0, 1'b0);
        set_ops(4'h2, 6'h0, 32'd1, 32'd2, 16'h0, 1'b0, 1'b0);
        tick();
        chk_flags("pipe3", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

        set_ops(4'h1, 6'h0, 32'd7, 32'd7, 16'h0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        chk("hold.result", bus.result, 32'hFFFFFFFF);
        chk("hold.valid", {31'b0, bus.out_valid}, 32'd0);
        tick();
        chk("hold2.result", bus.result, 32'hFFFFFFFF);
        chk("hold2.zero", {31'b0, bus.zero}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
